hwag_coil_sequencer: RTL and testbench

//  Parametrised N-channel coil driver fed by the HWAG master angle counter (acnt).
//  Per channel: phase offset, dwell-start/spark angles via double-buffered shadow regs,
//  per-channel FSM, over-dwell guard with sticky fault. Sits after acnt; replaces fixed coil14/coil23 logic.

---
 rtl/hwag_pkg.sv | 19 +
 rtl/hwag_coil_channel.sv | 151 +++++++++++++++
 rtl/hwag_coil_sequencer.sv | 66 ++++++
 tb/tb_hwag_coil_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared types and defaults for the HWAG coil sequencer.
package hwag_pkg;

  localparam int unsigned ANG_MAX_DEF = 3839;

  typedef enum logic [1:0] {
    WR_SET    = 2'd0,
    WR_SPARK  = 2'd1,
    WR_OFFSET = 2'd2,
    WR_CTRL   = 2'd3
  } wr_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CHARGE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/hwag_coil_channel.sv
// One coil channel: phase-shifted local angle, double-buffered angle regs,
// charge FSM and over-dwell guard with sticky fault.
module hwag_coil_channel
  import hwag_pkg::*;
#(
  parameter int unsigned ANG_WIDTH   = 24,
  parameter int unsigned ANG_MAX     = ANG_MAX_DEF,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned DWELL_MAX   = 1280
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hwag_start,
  input  logic [ANG_WIDTH-1:0] acnt,
  input  logic                 acnt_tick,
  input  logic                 wr_en,
  input  wr_sel_e              wr_sel,
  input  logic [ANG_WIDTH-1:0] wr_data,
  output logic                 wr_reject_c,
  output logic                 coil_out,
  output logic                 spark,
  output logic                 fault
);

  localparam int unsigned LW = ANG_WIDTH + 1;
  localparam logic [LW-1:0]          ANG_MAX_L = LW'(ANG_MAX);
  localparam logic [LW-1:0]          ANG_MOD_L = LW'(ANG_MAX + 1);
  localparam logic [ANG_WIDTH-1:0]   ANG_LIM   = ANG_WIDTH'(ANG_MAX);
  localparam logic [DWELL_WIDTH-1:0] DWELL_LIM = DWELL_WIDTH'(DWELL_MAX);

  ch_state_e              state_q, state_d;
  logic                   coil_q, coil_d, spark_q, spark_d, fault_q, fault_d, en_q, en_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, dwell_inc;
  logic [ANG_WIDTH-1:0]   set_p_q, set_p_d, spk_p_q, spk_p_d, off_p_q, off_p_d;
  logic [ANG_WIDTH-1:0]   set_a_q, set_a_d, spk_a_q, spk_a_d, off_a_q, off_a_d;
  logic [LW-1:0]          loc_sum;
  logic [ANG_WIDTH-1:0]   loc;

  assign wr_reject_c = wr_en & (wr_data > ANG_LIM);
  assign dwell_inc   = dwell_q + DWELL_WIDTH'(1);

  always_comb begin
    loc_sum = {1'b0, acnt} + {1'b0, off_a_q};
    if (loc_sum > ANG_MAX_L) loc = ANG_WIDTH'(loc_sum - ANG_MOD_L);
    else                     loc = ANG_WIDTH'(loc_sum);
  end

  always_comb begin
    state_d = state_q;
    coil_d  = coil_q;
    spark_d = 1'b0;
    fault_d = fault_q;
    en_d    = en_q;
    dwell_d = dwell_q;
    set_p_d = set_p_q;
    spk_p_d = spk_p_q;
    off_p_d = off_p_q;
    set_a_d = set_a_q;
    spk_a_d = spk_a_q;
    off_a_d = off_a_q;

    if (!hwag_start || !en_q) begin
      state_d = ST_IDLE;
      coil_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (acnt_tick && (loc == set_a_q) && (loc != spk_a_q)) begin
            state_d = ST_CHARGE;
            coil_d  = 1'b1;
            dwell_d = '0;
          end
        end
        ST_CHARGE: begin
          if (acnt_tick) begin
            dwell_d = dwell_inc;
            // Spark match takes priority over the over-dwell cut-off.
            if (loc == spk_a_q) begin
              state_d = ST_WAIT;
              coil_d  = 1'b0;
              spark_d = 1'b1;
            end else if (dwell_inc == DWELL_LIM) begin
              state_d = ST_WAIT;
              coil_d  = 1'b0;
              fault_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          coil_d  = 1'b0;
        end
      endcase
    end

    // Active angles only change between dwells, never inside one.
    if ((state_q == ST_IDLE) || (acnt_tick && (loc == '0) && (state_q != ST_CHARGE))) begin
      set_a_d = set_p_q;
      spk_a_d = spk_p_q;
      off_a_d = off_p_q;
    end

    if (wr_en && !wr_reject_c) begin
      case (wr_sel)
        WR_SET:    set_p_d = wr_data;
        WR_SPARK:  spk_p_d = wr_data;
        WR_OFFSET: off_p_d = wr_data;
        WR_CTRL: begin
          en_d = wr_data[0];
          if (wr_data[1]) fault_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      coil_q  <= 1'b0;
      spark_q <= 1'b0;
      fault_q <= 1'b0;
      en_q    <= 1'b0;
      dwell_q <= '0;
      set_p_q <= '0;
      spk_p_q <= '0;
      off_p_q <= '0;
      set_a_q <= '0;
      spk_a_q <= '0;
      off_a_q <= '0;
    end else begin
      state_q <= state_d;
      coil_q  <= coil_d;
      spark_q <= spark_d;
      fault_q <= fault_d;
      en_q    <= en_d;
      dwell_q <= dwell_d;
      set_p_q <= set_p_d;
      spk_p_q <= spk_p_d;
      off_p_q <= off_p_d;
      set_a_q <= set_a_d;
      spk_a_q <= spk_a_d;
      off_a_q <= off_a_d;
    end
  end

  assign coil_out = coil_q;
  assign spark    = spark_q;
  assign fault    = fault_q;

endmodule

// File: rtl/hwag_coil_sequencer.sv
// N-channel coil sequencer driven by the HWAG master angle counter.
// Decodes config writes to per-channel instances and flags rejected writes.
module hwag_coil_sequencer
  import hwag_pkg::*;
#(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned ANG_WIDTH   = 24,
  parameter int unsigned ANG_MAX     = ANG_MAX_DEF,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned DWELL_MAX   = 1280,
  localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hwag_start,
  input  logic [ANG_WIDTH-1:0] acnt,
  input  logic                 acnt_tick,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [1:0]           wr_sel,
  input  logic [ANG_WIDTH-1:0] wr_data,
  output logic [CH_NUM-1:0]    coil_out,
  output logic [CH_NUM-1:0]    spark,
  output logic [CH_NUM-1:0]    fault,
  output logic                 wr_err
);

  logic [CH_NUM-1:0] ch_wr_en_c, ch_reject_c;
  logic              ch_bad_c;
  logic              wr_err_q, wr_err_d;

  assign ch_bad_c = (32'(wr_ch) >= CH_NUM);
  assign wr_err_d = wr_en & (ch_bad_c | (|ch_reject_c));

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign ch_wr_en_c[i] = wr_en & ~ch_bad_c & (32'(wr_ch) == 32'(i));

    hwag_coil_channel #(
      .ANG_WIDTH  (ANG_WIDTH),
      .ANG_MAX    (ANG_MAX),
      .DWELL_WIDTH(DWELL_WIDTH),
      .DWELL_MAX  (DWELL_MAX)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .hwag_start (hwag_start),
      .acnt       (acnt),
      .acnt_tick  (acnt_tick),
      .wr_en      (ch_wr_en_c[i]),
      .wr_sel     (wr_sel_e'(wr_sel)),
      .wr_data    (wr_data),
      .wr_reject_c(ch_reject_c[i]),
      .coil_out   (coil_out[i]),
      .spark      (spark[i]),
      .fault      (fault[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_hwag_coil_sequencer.sv
// Directed scenarios with randomized tick spacing and background writes,
// checked every cycle against an angle-rule reference model.
module tb_hwag_coil_sequencer;

  localparam int CH   = 4;
  localparam int AW   = 24;
  localparam int AMAX = 3839;
  localparam int DMAX = 1280;

  logic          clk = 1'b0;
  logic          rst, hwag_start, acnt_tick, wr_en, wr_err;
  logic [AW-1:0] acnt, wr_data;
  logic [1:0]    wr_ch, wr_sel;
  logic [CH-1:0] coil_out, spark, fault, prev_coil;

  always #5 clk = ~clk;

  hwag_coil_sequencer dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt), .acnt_tick(acnt_tick),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel), .wr_data(wr_data),
    .coil_out(coil_out), .spark(spark), .fault(fault), .wr_err(wr_err)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model: pending/active angle sets plus armed/charging flags per channel.
  int m_pset[CH], m_pspk[CH], m_poff[CH], m_aset[CH], m_aspk[CH], m_aoff[CH], m_cnt[CH];
  bit m_en[CH], m_flt[CH], m_run[CH], m_chg[CH], m_spk[CH];
  bit m_werr;
  int rise_at[CH], fall_at[CH], spk_cnt[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_pset[c] = 0; m_pspk[c] = 0; m_poff[c] = 0;
      m_aset[c] = 0; m_aspk[c] = 0; m_aoff[c] = 0; m_cnt[c] = 0;
      m_en[c] = 0; m_flt[c] = 0; m_run[c] = 0; m_chg[c] = 0; m_spk[c] = 0;
    end
    m_werr = 0;
    prev_coil = '0;
  endtask

  task automatic m_step(input bit hs, input int a, input bit tk, input bit we,
                        input int wc, input int ws, input int wd);
    bit bad;
    bad = we && (wd > AMAX);
    for (int c = 0; c < CH; c++) begin
      int  loc;
      bit  xfer;
      loc  = (a + m_aoff[c]) % (AMAX + 1);
      xfer = !m_run[c] || (tk && loc == 0 && !m_chg[c]);
      m_spk[c] = 0;
      if (!hs || !m_en[c]) begin
        m_run[c] = 0; m_chg[c] = 0;
      end else if (!m_run[c]) begin
        m_run[c] = 1;
      end else if (tk) begin
        if (!m_chg[c]) begin
          if (loc == m_aset[c] && loc != m_aspk[c]) begin m_chg[c] = 1; m_cnt[c] = 0; end
        end else begin
          m_cnt[c]++;
          if (loc == m_aspk[c])   begin m_chg[c] = 0; m_spk[c] = 1; end
          else if (m_cnt[c] == DMAX) begin m_chg[c] = 0; m_flt[c] = 1; end
        end
      end
      if (xfer) begin m_aset[c] = m_pset[c]; m_aspk[c] = m_pspk[c]; m_aoff[c] = m_poff[c]; end
      if (we && !bad && wc == c) begin
        case (ws)
          0: m_pset[c] = wd;
          1: m_pspk[c] = wd;
          2: m_poff[c] = wd;
          default: begin m_en[c] = wd[0]; if (wd[1]) m_flt[c] = 0; end
        endcase
      end
    end
    m_werr = bad;
  endtask

  task automatic cyc(input bit tk, input int a, input bit we, input int wc, input int ws, input int wd);
    logic [CH-1:0] e_coil, e_spk, e_flt;
    acnt_tick = tk; acnt = AW'(a); wr_en = we; wr_ch = 2'(wc); wr_sel = 2'(ws); wr_data = AW'(wd);
    m_step(hwag_start, a, tk, we, wc, ws, wd);
    @(posedge clk); #1;
    for (int c = 0; c < CH; c++) begin
      e_coil[c] = m_chg[c]; e_spk[c] = m_spk[c]; e_flt[c] = m_flt[c];
    end
    chk("coil_out", 32'(coil_out), 32'(e_coil));
    chk("spark", 32'(spark), 32'(e_spk));
    chk("fault", 32'(fault), 32'(e_flt));
    chk("wr_err", 32'(wr_err), 32'(m_werr));
    for (int c = 0; c < CH; c++) begin
      if (coil_out[c] && !prev_coil[c]) rise_at[c] = a;
      if (!coil_out[c] && prev_coil[c]) fall_at[c] = a;
      if (spark[c]) spk_cnt[c]++;
    end
    prev_coil = coil_out;
    acnt_tick = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    cyc(0, 0, 1, ch, sel, data);
  endtask

  task automatic clr_track();
    for (int c = 0; c < CH; c++) begin rise_at[c] = -1; fall_at[c] = -1; spk_cnt[c] = 0; end
  endtask

  // Ticks with random gaps; gaps may carry random writes to channels 2/3.
  task automatic sweep(input int from, input int to);
    for (int a = from; a <= to; a++) begin
      cyc(1, a, 0, 0, 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0)
          cyc(0, int'($urandom_range(0, 24'hFFFFFF)), 1, int'($urandom_range(2, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4300)));
        else
          cyc(0, int'($urandom_range(0, 24'hFFFFFF)), 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hwag_start = 1'b0; acnt_tick = 1'b0; acnt = '0;
    wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
    m_reset();
    clr_track();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_coil", 32'(coil_out), 0);
    chk("reset_spark", 32'(spark), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_wr_err", 32'(wr_err), 0);
    rst = 1'b0;
    hwag_start = 1'b1;

    // Asynchronous reset in the middle of a dwell
    wr(0, 0, 10); wr(0, 1, 50); wr(0, 3, 1);
    sweep(0, 30);
    chk("t1_charging_before_rst", 32'(coil_out[0]), 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_coil_async", 32'(coil_out), 0);
    chk("t1_rst_spark_async", 32'(spark), 0);
    chk("t1_rst_fault_async", 32'(fault), 0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clr_track();
    sweep(0, 60);
    chk("t1_disabled_after_rst", 32'(rise_at[0]), 32'(-1));

    // Basic dwell on ch0 and phase-shifted ch1
    wr(0, 2, 0); wr(0, 0, 3000); wr(0, 1, 3839); wr(0, 3, 1);
    wr(1, 2, 1920); wr(1, 0, 3000); wr(1, 1, 3839); wr(1, 3, 1);
    clr_track();
    sweep(0, 3839);
    chk("t2_ch0_rise", 32'(rise_at[0]), 3000);
    chk("t2_ch0_fall", 32'(fall_at[0]), 3839);
    chk("t2_ch0_sparks", 32'(spk_cnt[0]), 1);
    chk("t3_ch1_rise", 32'(rise_at[1]), 1080);
    chk("t3_ch1_fall", 32'(fall_at[1]), 1919);
    chk("t3_ch1_sparks", 32'(spk_cnt[1]), 1);

    // Set-angle rewrite during a dwell takes effect next revolution
    clr_track();
    sweep(0, 3100);
    chk("t4_charging", 32'(coil_out[0]), 1);
    wr(0, 0, 2000);
    sweep(3101, 3839);
    chk("t4_fall_unchanged", 32'(fall_at[0]), 3839);
    chk("t4_spark_unchanged", 32'(spk_cnt[0]), 1);
    rise_at[0] = -1;
    sweep(0, 2100);
    chk("t4_next_rise", 32'(rise_at[0]), 2000);

    // Over-dwell cut-off and fault clear
    wr(0, 0, 100); wr(0, 1, 3000);
    sweep(2101, 3839);
    clr_track();
    sweep(0, 1500);
    chk("t5_rise", 32'(rise_at[0]), 100);
    chk("t5_overdwell_fall", 32'(fall_at[0]), 100 + DMAX);
    chk("t5_fault_set", 32'(fault[0]), 1);
    chk("t5_no_spark", 32'(spk_cnt[0]), 0);
    wr(0, 3, 3);
    chk("t5_fault_cleared", 32'(fault[0]), 0);

    // Sync loss mid-dwell, rejected offset write
    chk("t6_ch1_charging", 32'(coil_out[1]), 1);
    hwag_start = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_all_coils_off", 32'(coil_out), 0);
    wr(0, 2, 3840);
    chk("t6_wr_err_pulse", 32'(wr_err), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t6_wr_err_single", 32'(wr_err), 0);
    hwag_start = 1'b1;
    sweep(1501, 3839);
    rise_at[0] = -1;
    sweep(0, 200);
    chk("t6_offset_unchanged", 32'(rise_at[0]), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
